// File: rtl/expipe_pkg.sv
// Shared execution-pipe types: CDB payload and unit index widths.
package expipe_pkg;

  localparam int unsigned EU_N = 8;

  typedef logic [$clog2(EU_N)-1:0] eu_idx_t;

  typedef struct packed {
    logic [5:0]  rob_tag;
    logic [31:0] value;
  } cdb_data_t;

endpackage

// File: rtl/cdb_sched_rr_prio_sel.sv
// Rotating priority select: first set request at or after ptr, wrapping modulo N.
module rr_prio_sel #(
  parameter int unsigned N = 7
) (
  input  logic [0:N-1]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int unsigned PW = $clog2(N);

  int unsigned j;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_sched.sv
// CDB arbiter: max-priority lane with starvation guard, round-robin ordinary lanes,
// one-entry registered output with valid/ready handshake toward the ROB.
module cdb_sched
  import expipe_pkg::*;
#(
  parameter int unsigned EU_N       = expipe_pkg::EU_N,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    max_prio_valid_i,
  output logic                    max_prio_ready_o,
  input  cdb_data_t               max_prio_data_i,
  input  logic [0:EU_N-2]         valid_i,
  output logic [0:EU_N-2]         ready_o,
  input  cdb_data_t               data_i [0:EU_N-2],
  input  logic                    rob_ready_i,
  output logic                    rob_valid_o,
  output cdb_data_t               cdb_data_o,
  output logic                    served_max_prio_o,
  output logic [$clog2(EU_N)-1:0] served_o
);

  localparam int unsigned ON = EU_N - 1;
  localparam int unsigned PW = $clog2(ON);
  localparam int unsigned SW = $clog2(EU_N);
  localparam int unsigned CW = $clog2(STARVE_LIM + 1);

  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] starve_cnt;
  logic [PW-1:0] sel_idx;
  logic          sel_any;
  logic          any_ord;
  logic          slot_free;
  logic          grant_en;
  logic          guard;
  logic          grant_mp;
  logic          grant_ord;

  rr_prio_sel #(
    .N (ON)
  ) u_sel (
    .req     (valid_i),
    .ptr     (rr_ptr),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  assign any_ord   = |valid_i;
  assign slot_free = !rob_valid_o || rob_ready_i;
  // Readys are gated by rst_n_i so no unit sees an accept while reset is held.
  assign grant_en  = rst_n_i && slot_free && !flush_i;
  assign guard     = (starve_cnt == CW'(STARVE_LIM)) && any_ord;
  assign grant_mp  = grant_en && max_prio_valid_i && !guard;
  assign grant_ord = grant_en && !grant_mp && sel_any;

  assign max_prio_ready_o = grant_mp;

  always_comb begin
    ready_o = '0;
    if (grant_ord) ready_o[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rob_valid_o       <= 1'b0;
      cdb_data_o        <= '0;
      served_o          <= '0;
      served_max_prio_o <= 1'b0;
      rr_ptr            <= '0;
      starve_cnt        <= '0;
    end else if (flush_i) begin
      rob_valid_o <= 1'b0;
      rr_ptr      <= '0;
      starve_cnt  <= '0;
    end else if (grant_mp) begin
      rob_valid_o       <= 1'b1;
      cdb_data_o        <= max_prio_data_i;
      served_o          <= '0;
      served_max_prio_o <= 1'b1;
      if (!any_ord)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_LIM))
        starve_cnt <= starve_cnt + CW'(1);
    end else if (grant_ord) begin
      rob_valid_o       <= 1'b1;
      cdb_data_o        <= data_i[sel_idx];
      served_o          <= SW'(sel_idx) + SW'(1);
      served_max_prio_o <= 1'b0;
      rr_ptr            <= (sel_idx == PW'(ON - 1)) ? '0 : sel_idx + PW'(1);
      starve_cnt        <= '0;
    end else if (rob_ready_i) begin
      rob_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_sched.sv
// Directed vector bench for cdb_sched with EU_N=4, STARVE_LIM=2.
module tb_cdb_sched;
  import expipe_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic           flush_i;
  logic           max_prio_valid_i;
  logic           max_prio_ready_o;
  cdb_data_t      max_prio_data_i;
  logic [0:2]     valid_i;
  logic [0:2]     ready_o;
  cdb_data_t      data_i [0:2];
  logic           rob_ready_i;
  logic           rob_valid_o;
  cdb_data_t      cdb_data_o;
  logic           served_max_prio_o;
  logic [1:0]     served_o;

  int checks = 0;
  int errors = 0;

  cdb_sched #(
    .EU_N       (4),
    .STARVE_LIM (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .flush_i           (flush_i),
    .max_prio_valid_i  (max_prio_valid_i),
    .max_prio_ready_o  (max_prio_ready_o),
    .max_prio_data_i   (max_prio_data_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .data_i            (data_i),
    .rob_ready_i       (rob_ready_i),
    .rob_valid_o       (rob_valid_o),
    .cdb_data_o        (cdb_data_o),
    .served_max_prio_o (served_max_prio_o),
    .served_o          (served_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic cdb_data_t payload(input int unsigned src);
    cdb_data_t d;
    d.rob_tag = 6'(src + 8);
    d.value   = 32'hA5A0_0000 + 32'(src * 32'h111);
    return d;
  endfunction

  task automatic check(input string name, input int unsigned idx,
                       input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", name, idx, got, want);
    end
  endtask

  typedef struct {
    logic       mp;
    logic [0:2] v;
    logic       rdy;
    logic       fl;
    logic       e_mp;
    logic [0:2] e_rdy;
    logic       e_val;
    logic [1:0] e_srv;
    logic       e_smp;
    logic       chk;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};

    max_prio_data_i = payload(0);
    for (int i = 0; i < 3; i++) data_i[i] = payload(i + 1);

    // Reset held with every requester active: nothing may be accepted.
    rst_n_i          = 1'b0;
    flush_i          = 1'b0;
    max_prio_valid_i = 1'b1;
    valid_i          = 3'b111;
    rob_ready_i      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      check("rst_mp_ready", c, 64'(max_prio_ready_o), 64'(1'b0));
      check("rst_ready",    c, 64'(ready_o),          64'(3'b000));
      check("rst_rob_valid", c, 64'(rob_valid_o),     64'(1'b0));
      check("rst_served",   c, 64'(served_o),         64'(2'd0));
      check("rst_data",     c, 64'(cdb_data_o),       64'(0));
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk_i);
      max_prio_valid_i = tbl[i].mp;
      valid_i          = tbl[i].v;
      rob_ready_i      = tbl[i].rdy;
      flush_i          = tbl[i].fl;
      #1;
      check("mp_ready", i, 64'(max_prio_ready_o), 64'(tbl[i].e_mp));
      check("ready",    i, 64'(ready_o),          64'(tbl[i].e_rdy));
      @(posedge clk_i);
      #1;
      check("rob_valid", i, 64'(rob_valid_o), 64'(tbl[i].e_val));
      if (tbl[i].chk) begin
        check("served",    i, 64'(served_o),          64'(tbl[i].e_srv));
        check("served_mp", i, 64'(served_max_prio_o), 64'(tbl[i].e_smp));
        check("cdb_data",  i, 64'(cdb_data_o),        64'(payload(32'(tbl[i].e_srv))));
      end
    end

    // Reset asserted while a result sits in the stalled output register.
    @(negedge clk_i);
    flush_i          = 1'b0;
    max_prio_valid_i = 1'b1;
    valid_i          = 3'b000;
    rob_ready_i      = 1'b0;
    @(posedge clk_i);
    #1;
    check("midrst_loaded", 0, 64'(rob_valid_o), 64'(1'b1));
    #2;
    rst_n_i = 1'b0;
    #1;
    check("midrst_async_clear", 0, 64'(rob_valid_o),      64'(1'b0));
    check("midrst_mp_ready",    0, 64'(max_prio_ready_o), 64'(1'b0));
    rob_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_no_grant", 0, 64'(rob_valid_o), 64'(1'b0));
    @(negedge clk_i);
    max_prio_valid_i = 1'b0;
    rst_n_i          = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_idle", 0, 64'(rob_valid_o), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_sched.md
Name: cdb_sched

Overview:
- Registered, fair arbiter feeding the common data bus (CDB) from the execution units to the ROB and reservation stations.
- One maximum-priority lane (e.g. load/branch unit) plus EU_N-1 ordinary lanes.
- Ordinary lanes served round-robin; max-priority lane protected by a bounded starvation guard.
- Winner's payload captured in a one-entry output register, so the CDB is broadcast from a flop with a valid/ready handshake to the ROB.

Parameters:
- EU_N, 8, total number of units on the CDB including the max-priority one; ordinary lanes = EU_N-1, must be >= 3
- STARVE_LIM, 4, consecutive max-priority grants tolerated while an ordinary lane waits
- Payload type: cdb_data_t (from expipe_pkg)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush: discard pending output and guard state
- max_prio_valid_i  in  1  max-priority unit has a result
- max_prio_ready_o  out  1  max-priority result accepted this cycle
- max_prio_data_i  in  cdb_data_t  max-priority payload
- valid_i  in  [0:EU_N-2]  ordinary unit results valid
- ready_o  out  [0:EU_N-2]  one-hot grant/accept per ordinary unit
- data_i  in  [0:EU_N-2] x cdb_data_t  ordinary payloads
- rob_ready_i  in  1  ROB/CDB consumer accepts the output register
- rob_valid_o  out  1  output register holds a valid result
- cdb_data_o  out  cdb_data_t  registered payload
- served_max_prio_o  out  1  registered: current output came from max-priority lane
- served_o  out  $clog2(EU_N)  registered source index: 0 = max-prio, i+1 = ordinary lane i

Behaviour:
Reset values:
- rob_valid_o=0, cdb_data_o=0, served_o=0, served_max_prio_o=0.
- rr_ptr=0, starve_cnt=0.
- All ready outputs 0 during reset.

Output slot and grants:
- slot_free = !rob_valid_o | rob_ready_i.
- A grant occurs only when slot_free && !flush_i; at most one ready asserted per cycle.

Arbitration, evaluated when slot_free:
- If max_prio_valid_i and not (starve_cnt==STARVE_LIM and |valid_i): grant max-prio (max_prio_ready_o=1).
- Else if |valid_i: grant the first set valid_i[j] scanning j = rr_ptr, rr_ptr+1, ... with wrap modulo EU_N-1.

State updates:
- On an ordinary grant to j: rr_ptr <= (j+1) mod (EU_N-1); starve_cnt <= 0.
- On a max-prio grant with |valid_i: starve_cnt <= starve_cnt+1, saturating at STARVE_LIM.
- On a max-prio grant with no ordinary valid: starve_cnt <= 0.
- rr_ptr is unchanged by max-prio grants and idle cycles.

Output register:
- On any grant: rob_valid_o <= 1 and the winner's payload/index loaded next edge.
- Latency 1 cycle from accept to rob_valid_o.
- Else if rob_ready_i: rob_valid_o <= 0.
- While rob_valid_o && !rob_ready_i: cdb_data_o and served_o are held stable, no readys asserted.
- Back-to-back throughput is 1 result/cycle when rob_ready_i stays high.

Units:
- Units must hold valid and data until their ready is seen; valid may not be withdrawn except by flush.

Flush:
- flush_i has priority over everything.
- All readys 0 that cycle; rob_valid_o <= 0; starve_cnt <= 0; rr_ptr <= 0.
- Flush during a stalled output drops the held result.

Boundary cases:
- Wrap: rr_ptr = EU_N-2 with grant → rr_ptr = 0.
- Reset asserted mid-transfer: output cleared asynchronously, no grant completes.

Decomposition:
- expipe_pkg: EU_N, cdb_data_t; also an index typedef: logic [$clog2(EU_N)-1:0].
- Sub-module rr_prio_sel: combinational rotate-by-rr_ptr priority select returning grant index + any-valid.
- Registers, guard counter and handshake stay in cdb_sched.

Test Plan (EU_N=4, STARVE_LIM=2):
1. Reset with all valids high → no readys, rob_valid_o=0 until rst_n_i rises; first edge after reset grants max-prio, served_o=0.
2. valid_i=111, max-prio idle, rob_ready_i=1 → grants lane 0,1,2,0 on consecutive cycles; served_o 1,2,3,1 one cycle later.
3. max_prio_valid_i=1 continuously, valid_i=010 → max-prio, max-prio, lane 1, max-prio; starve_cnt returns to 0 after lane 1.
4. rob_ready_i=0 for 3 cycles with output valid → cdb_data_o and served_o constant, all readys 0; first cycle rob_ready_i=1 grants next requester in the same cycle.
5. flush_i while rob_valid_o=1, rob_ready_i=0 → next cycle rob_valid_o=0, rr_ptr=0, no grant during the flush cycle.
6. rr_ptr=2, valid_i=101 → lane 2 granted, rr_ptr wraps to 0, next grant lane 0.
